// File: rtl/mem_access_unit.sv
// RV64 load/store unit: one request at a time against a doubleword-wide data memory.
// Sub-doubleword stores do read-modify-write; misaligned requests answer without a memory cycle.
module mem_access_unit #(
    parameter int RD_LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [63:0] i_req_addr,
    input  logic [63:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [63:0] o_rsp_rdata,
    output logic        o_misaligned,
    output logic [63:0] o_mem_addr,
    output logic [63:0] o_mem_wdata,
    output logic        o_mem_wr,
    input  logic [63:0] i_mem_rdata
);

    localparam int CW = $clog2(RD_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic          r_we;
    logic [1:0]    r_size;
    logic          r_uns;
    logic [2:0]    r_lane;
    logic [63:0]   r_wdata;
    logic          r_misal;
    logic [CW-1:0] r_cnt;
    logic [63:0]   r_mem_addr;
    logic [63:0]   r_mem_wdata;
    logic [63:0]   r_rsp_rdata;

    logic          w_accept;
    logic          w_misal;
    logic          w_rd_done;
    logic [5:0]    w_sh;
    logic [63:0]   w_lane_mask;
    logic [63:0]   w_shifted;
    logic [63:0]   w_load_val;
    logic [63:0]   w_merged;

    function automatic logic [63:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    size_mask = 64'h0000_0000_0000_00FF;
            2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    assign w_accept  = i_req_valid && (r_state == S_IDLE);
    assign w_rd_done = (r_state == S_READ) && (r_cnt == CW'(1));

    always_comb begin
        case (i_req_size)
            2'd0:    w_misal = 1'b0;
            2'd1:    w_misal = i_req_addr[0];
            2'd2:    w_misal = |i_req_addr[1:0];
            default: w_misal = |i_req_addr[2:0];
        endcase
    end

    // Lane arithmetic works on the captured read data and the latched request.
    assign w_sh        = {r_lane, 3'b000};
    assign w_lane_mask = size_mask(r_size) << w_sh;
    assign w_shifted   = i_mem_rdata >> w_sh;
    assign w_merged    = (i_mem_rdata & ~w_lane_mask) | ((r_wdata << w_sh) & w_lane_mask);

    always_comb begin
        case (r_size)
            2'd0:    w_load_val = {{56{~r_uns & w_shifted[7]}},  w_shifted[7:0]};
            2'd1:    w_load_val = {{48{~r_uns & w_shifted[15]}}, w_shifted[15:0]};
            2'd2:    w_load_val = {{32{~r_uns & w_shifted[31]}}, w_shifted[31:0]};
            default: w_load_val = w_shifted;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_misal) begin
                        w_next = S_RESP;
                    end else if (i_req_we && (i_req_size == 2'd3)) begin
                        w_next = S_WRITE;
                    end else begin
                        w_next = S_READ;
                    end
                end
            end
            S_READ: begin
                if (w_rd_done) begin
                    w_next = r_we ? S_WRITE : S_RESP;
                end
            end
            S_WRITE: w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready  = (r_state == S_IDLE);
        o_rsp_valid  = (r_state == S_RESP);
        o_mem_wr     = (r_state == S_WRITE);
        o_misaligned = (r_state == S_RESP) && r_misal;
    end

    assign o_rsp_rdata = r_rsp_rdata;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

    // rsp_rdata only changes on the edge that enters RESP, so it holds between responses.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_we        <= 1'b0;
            r_size      <= 2'd0;
            r_uns       <= 1'b0;
            r_lane      <= 3'd0;
            r_wdata     <= '0;
            r_misal     <= 1'b0;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rsp_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_we       <= i_req_we;
                r_size     <= i_req_size;
                r_uns      <= i_req_unsigned;
                r_lane     <= i_req_addr[2:0];
                r_wdata    <= i_req_wdata;
                r_misal    <= w_misal;
                r_cnt      <= CW'(RD_LATENCY);
                r_mem_addr <= {i_req_addr[63:3], 3'b000};
                if (w_misal) begin
                    r_rsp_rdata <= '0;
                end else if (i_req_we && (i_req_size == 2'd3)) begin
                    r_mem_wdata <= i_req_wdata;
                end
            end
            if (r_state == S_READ) begin
                r_cnt <= r_cnt - CW'(1);
                if (w_rd_done) begin
                    if (r_we) begin
                        r_mem_wdata <= w_merged;
                    end else begin
                        r_rsp_rdata <= w_load_val;
                    end
                end
            end
            if (r_state == S_WRITE) begin
                r_rsp_rdata <= '0;
            end
        end
    end

endmodule
